// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, payload type and PC helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // One buffered fetch result as presented to the IF/ID register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Parameterised synchronous FIFO with single-cycle flush; DEPTH must be a power of 2.
module if_fetch_unit_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer and occupancy update; flush overrides push and pop.
  always_comb begin
    do_push  = push_i && (count_q != FULL) && !flush_i;
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches, buffers returns
// and presents {instr, pc+4, pc, valid} to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_pc
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             init_q;

  logic [CNT_W-1:0] occupancy;
  logic             if_pop;
  logic             issue;
  logic             resp_drop;
  logic             resp_take;

  logic [31:0]      pcq_head;
  logic [CNT_W-1:0] pcq_count;
  fetch_entry_t     ibuf_wdata;
  fetch_entry_t     ibuf_head;
  logic [CNT_W-1:0] ibuf_count;

  // Issue, response routing and next-state for PC and counters; redirect wins.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    occupancy     = outstanding_q + ibuf_count;
    if_pop        = (ibuf_count != '0) && !id_stall;
    // A head pop this cycle frees its slot at the same edge, which keeps
    // one fetch per cycle with a 1-cycle memory.
    imem_req      = init_q && !redirect_valid && ((occupancy - CNT_W'(if_pop)) < DEPTH_C);
    issue         = imem_req && imem_gnt;
    resp_drop     = imem_rvalid && (drop_q != '0);
    resp_take     = imem_rvalid && (drop_q == '0) && !redirect_valid;
    if (redirect_valid) begin
      pc_d          = align_pc(redirect_pc);
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (issue)     pc_d   = next_pc(pc_q);
      if (resp_drop) drop_d = drop_q - ONE;
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp_take);
    end
  end

  // PC and counter registers; init_q holds off requests for one cycle after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      init_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      init_q        <= 1'b1;
    end
  end

  // PCs of granted, not yet returned fetches.
  if_fetch_unit_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (issue),
    .pop_i   (resp_take),
    .wdata_i (pc_q),
    .rdata_o (pcq_head),
    .count_o (pcq_count)
  );

  assign ibuf_wdata = '{pc: pcq_head, instr: imem_rdata};

  // Returned instructions waiting for decode.
  if_fetch_unit_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (resp_take),
    .pop_i   (if_pop),
    .wdata_i (ibuf_wdata),
    .rdata_o (ibuf_head),
    .count_o (ibuf_count)
  );

  assign imem_addr      = pc_q;
  assign if_valid       = (ibuf_count != '0);
  assign if_instruction = if_valid ? ibuf_head.instr : NOP_INSTR;
  assign if_pc          = if_valid ? ibuf_head.pc : 32'h0;
  assign if_pc_plus4    = if_valid ? next_pc(ibuf_head.pc) : 32'h0;

  // A response with nothing in flight means the memory protocol was broken.
  a_rvalid_expected: assert property (@(posedge clock) disable iff (!reset)
    imem_rvalid |-> ((outstanding_q != '0) || (drop_q != '0)));

  // The PC queue always holds exactly one entry per outstanding fetch.
  a_pcq_tracks: assert property (@(posedge clock) disable iff (!reset)
    outstanding_q == pcq_count);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, all checked
// against a queue-level model of memory transactions and the decode buffer.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_pc;

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc_plus4    (if_pc_plus4),
    .if_pc          (if_pc)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory transactions in flight: live=0 once squashed by a redirect.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] bq[$];
  logic [31:0] m_pc;
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  bit          fresh = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_pc4, o_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].live) n++;
    return n;
  endfunction

  function automatic bit resp_now();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit gnt, input bit redir, input logic [31:0] rpc, input bit stall);
    bit          rv, pop, exp_req, issued, vld;
    logic [31:0] hd;
    mreq_t       e;
    int          d;
    e = '{addr: 32'h0, due: 0, live: 1'b0};
    @(negedge clock);
    reset          = 1'b1;
    imem_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_stall       = stall;
    rv             = resp_now();
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = if_valid;
    o_pc    = if_pc;
    o_pc4   = if_pc_plus4;
    o_instr = if_instruction;
    vld     = (bq.size() > 0);
    hd      = vld ? bq[0] : 32'h0;
    pop     = vld && !stall;
    exp_req = !fresh && !redir && ((live_cnt() + bq.size() - int'(pop)) < DEPTH);
    chk("imem_req", 32'(o_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", o_addr, m_pc);
    chk("if_valid", 32'(o_valid), 32'(vld));
    chk("if_pc", o_pc, vld ? hd : 32'h0);
    chk("if_pc_plus4", o_pc4, vld ? hd + 32'd4 : 32'h0);
    chk("if_instruction", o_instr, vld ? mem_word(hd) : 32'h0);
    @(posedge clock);
    issued = exp_req && gnt;
    if (rv) e = mq.pop_front();
    if (redir) begin
      foreach (mq[i]) mq[i].live = 1'b0;
      bq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(bq.pop_front());
      if (rv && e.live) bq.push_back(e.addr);
      if (issued) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        mq.push_back('{addr: m_pc, due: d, live: 1'b1});
        last_due = d;
        m_pc = m_pc + 32'd4;
      end
    end
    fresh = 1'b0;
    cyc++;
  endtask

  // Reset the DUT and the memory together.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset          = 1'b0;
      imem_gnt       = 1'b0;
      redirect_valid = 1'b0;
      id_stall       = 1'b0;
      imem_rvalid    = 1'b0;
      @(posedge clock);
      cyc++;
    end
    mq.delete();
    bq.delete();
    m_pc     = RST_PC;
    fresh    = 1'b1;
    last_due = cyc;
  endtask

  initial begin
    logic [31:0] frozen;
    int          k;

    // Reset, then streaming with a 1-cycle memory across the address wrap.
    do_reset(3);
    lat = 1;
    cycle(1, 0, 0, 0);
    chk("rst_req_low", 32'(o_req), 32'h0);
    chk("rst_valid_low", 32'(o_valid), 32'h0);
    cycle(1, 0, 0, 0);
    chk("first_addr", o_addr, 32'hFFFF_FFF8);
    cycle(1, 0, 0, 0);
    chk("no_valid_yet", 32'(o_valid), 32'h0);
    cycle(1, 0, 0, 0);
    chk("first_pc", o_pc, 32'hFFFF_FFF8);
    chk("first_pc4", o_pc4, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0);
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", o_pc4, 32'h0000_0000);
    cycle(1, 0, 0, 0);
    chk("pc0", o_pc, 32'h0);
    chk("pc0_plus4", o_pc4, 32'h4);
    cycle(1, 0, 0, 0);
    chk("pc4", o_pc, 32'h4);
    chk("pc4_plus4", o_pc4, 32'h8);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      chk("stream_valid", 32'(o_valid), 32'h1);
    end

    // Decode stall with a full buffer, then release.
    cycle(1, 0, 0, 1);
    frozen = o_pc;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1);
      chk("stall_hold_pc", o_pc, frozen);
      chk("stall_req_low", 32'(o_req), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0);
      chk("release_seq", o_pc, frozen + 32'(4 * i));
    end

    // Redirect with two fetches in flight on a 3-cycle memory.
    lat = 3;
    k = 0;
    while (live_cnt() != 2 && k < 10) begin cycle(1, 0, 0, 0); k++; end
    chk("t3_two_outstanding", 32'(live_cnt()), 32'd2);
    cycle(1, 1, 32'h0000_0102, 0);
    cycle(1, 0, 0, 0);
    chk("t3_valid_after_redir", 32'(o_valid), 32'h0);
    chk("t3_refetch_addr", o_addr, 32'h100);
    k = 0;
    while (!o_valid && k < 12) begin cycle(1, 0, 0, 0); k++; end
    chk("t3_valid_seen", 32'(o_valid), 32'h1);
    chk("t3_first_pc", o_pc, 32'h100);

    // Redirect, stall and a response all in one cycle.
    lat = 2;
    k = 0;
    while (!(resp_now() && bq.size() > 0) && k < 20) begin cycle(1, 0, 0, 0); k++; end
    chk("t4_setup", 32'(resp_now() && bq.size() > 0), 32'h1);
    cycle(1, 1, 32'h200, 1);
    cycle(1, 0, 0, 0);
    chk("t4_buffer_empty", 32'(o_valid), 32'h0);
    chk("t4_refetch_addr", o_addr, 32'h200);
    k = 0;
    while (!o_valid && k < 12) begin cycle(1, 0, 0, 0); k++; end
    chk("t4_first_pc", o_pc, 32'h200);

    // Reset with two fetches outstanding.
    lat = 3;
    k = 0;
    while (live_cnt() != 2 && k < 10) begin cycle(1, 0, 0, 0); k++; end
    chk("t6_two_outstanding", 32'(live_cnt()), 32'd2);
    do_reset(2);
    cycle(1, 0, 0, 0);
    chk("t6_req_low", 32'(o_req), 32'h0);
    chk("t6_valid_low", 32'(o_valid), 32'h0);
    cycle(1, 0, 0, 0);
    chk("t6_req_high", 32'(o_req), 32'h1);
    chk("t6_first_addr", o_addr, RST_PC);

    // Random traffic: grant, latency, stall and redirect all varied.
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 3));
      if (i == 200) do_reset(1);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
